vector_mem_unit: RTL and testbench
==================================

VECTOR_MEM_UNIT -- requirements
Module: vector_mem_unit

Interface
REQ-001 Parameter LANES, 16, number of vector lanes per transfer.
REQ-002 Parameter LANE_W, 16, bits per lane and per memory word.
REQ-003 Parameter ADDR_W, 16, memory word-address width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request from execute stage, sampled on rising edge.
REQ-007 opcode  input  4  op code: VLD=0100, VST=0101, SST=0011; all other values are non-memory.
REQ-008 addr  input  ADDR_W  base word address, taken from the ALU result low bits.
REQ-009 st_data  input  LANES*LANE_W  store data; lane i = bits [16i+15:16i].
REQ-010 mem_addr  output  ADDR_W  memory word address.
REQ-011 mem_wdata  output  LANE_W  memory write data.
REQ-012 mem_re  output  1  read request.
REQ-013 mem_we  output  1  write request.
REQ-014 mem_rdata  input  LANE_W  read data, valid in the cycle mem_ready=1 with mem_re=1.
REQ-015 mem_ready  input  1  memory accepts or completes the current word this cycle.
REQ-016 ld_data  output  LANES*LANE_W  loaded vector register.
REQ-017 busy  output  1  high whenever state is not IDLE; upstream stalls on it.
REQ-018 done  output  1  one-cycle completion pulse.

Function
REQ-019 States are IDLE, LOAD, STORE and DONE.
REQ-020 In IDLE, start=1 with VLD SHALL latch addr and go to LOAD with lane index 0.
REQ-021 In IDLE, start=1 with VST SHALL latch addr and st_data and go to STORE with count LANES.
REQ-022 In IDLE, start=1 with SST SHALL latch addr and st_data and go to STORE with count 1 (lane 0 only).
REQ-023 In IDLE, start with a non-memory opcode SHALL be ignored: no memory access, no done pulse.
REQ-024 start SHALL be ignored while busy=1; latched operands are unaffected.
REQ-025 Lane i address is latched addr + i, modulo 2^ADDR_W (wraps 0xFFFF to 0x0000).
REQ-026 LOAD: mem_re=1 and mem_addr = lane i address.
REQ-027 LOAD: on an edge with mem_ready=1, mem_rdata SHALL be written to ld_data lane i, then i increments; other lanes hold.
REQ-028 STORE: mem_we=1, mem_addr = lane i address and mem_wdata = latched lane i.
REQ-029 STORE: a word is complete on an edge with mem_ready=1, then i increments.
REQ-030 mem_ready=0 SHALL hold i, mem_addr, mem_wdata and the strobe unchanged (stall of any length).
REQ-031 Completion of the last lane SHALL move the state to DONE.
REQ-032 DONE: done=1, mem_re=0, mem_we=0; the next state is IDLE, so a new start is accepted on the edge following DONE.
REQ-033 mem_re and mem_we SHALL never both be 1; both are 0 in IDLE and DONE.
REQ-034 ld_data SHALL hold its value outside LOAD; a VLD result is complete when done=1.
REQ-035 Latency with mem_ready tied high: VLD/VST = LANES+1 cycles from the start edge to done; SST = 2 cycles.
REQ-036 mem_addr and mem_wdata SHALL be 0 when no strobe is asserted.

Reset
REQ-037 rst=1 at a rising edge SHALL force IDLE, clear the lane index and latched operands, and set ld_data=0, done=0, busy=0, mem_re=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-038 rst SHALL take priority over start and over an in-flight transfer (mid-operation abort).
REQ-039 An aborted transfer SHALL leave no done pulse and SHALL assert no strobe after the reset edge.

Verification
REQ-040 VLD, addr=0x0100, mem_ready=1, memory word at 0x0100+i = 0x3C00+i -> reads at 0x0100..0x010F, done in cycle 17, ld_data lane i = 0x3C00+i.
REQ-041 VST, addr=0x0200, st_data lane i = i, mem_ready low on every other cycle -> 16 writes of value i to 0x0200+i in order, outputs held across stalls, done once.
REQ-042 VLD, addr=0xFFF8 -> lane addresses 0xFFF8..0xFFFF, then 0x0000..0x0007.
REQ-043 SST, addr=0x0010, st_data[15:0]=0xABCD -> single write of 0xABCD to 0x0010, done in cycle 2.
REQ-044 rst asserted after lane 5 of a VLD -> next cycle IDLE with all outputs 0 and no done; a fresh VLD then completes normally.
REQ-045 start with a different addr while busy, and start with opcode VADD in IDLE -> both ignored; the addresses of the in-flight transfer are unchanged.

Source files
------------

// File: rtl/vector_mem_unit_if.sv
// Memory-side bus of the vector load/store unit: one word per beat,
// a read or write strobe, and a ready handshake from the memory.
interface vector_mem_unit_if #(
    parameter int ADDR_W = 16,
    parameter int LANE_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [LANE_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [LANE_W-1:0] mem_rdata;
    logic              mem_ready;

    // The load/store unit drives the request side.
    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_ready
    );

    // The memory answers with read data and ready.
    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/vector_mem_unit.sv
// Vector load/store unit: serialises a LANES-wide vector load (VLD), vector
// store (VST) or scalar store (SST) into one memory word per beat, with
// consecutive word addresses that wrap at 2^ADDR_W. All memory-side outputs
// are registered and stay frozen while the memory stalls with mem_ready=0.
module vector_mem_unit #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              opcode,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [LANES*LANE_W-1:0] st_data,
    vector_mem_unit_if.master       mem,
    output logic [LANES*LANE_W-1:0] ld_data,
    output logic                    busy,
    output logic                    done
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [3:0] OP_VLD = 4'b0100;
    localparam logic [3:0] OP_VST = 4'b0101;
    localparam logic [3:0] OP_SST = 4'b0011;

    localparam logic [IDX_W-1:0] LAST_VEC = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_DONE
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;        // lane currently on the bus
    logic [IDX_W-1:0]        last_idx;   // LANES-1 for vectors, 0 for SST
    logic [ADDR_W-1:0]       base_addr;
    logic [LANES*LANE_W-1:0] st_lat;

    logic [IDX_W-1:0]  idx_next;
    logic [ADDR_W-1:0] addr_next;
    logic              last_lane;

    // Next lane index never overflows: it is only used when idx < last_idx.
    assign idx_next  = idx + 1'b1;
    // Address arithmetic stays ADDR_W bits wide so it wraps naturally.
    assign addr_next = base_addr + ADDR_W'(idx_next);
    assign last_lane = (idx == last_idx);

    // Single FSM: accepts a request in IDLE, walks the lanes one beat per
    // mem_ready, pulses done for one cycle, then returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state        <= S_IDLE;
            idx          <= '0;
            last_idx     <= '0;
            base_addr    <= '0;
            st_lat       <= '0;
            // NOTE: ld_data is a flop bank, not a RAM macro, so it can and
            // must be cleared by reset; a true memory array would not be.
            ld_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem.mem_re    <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (opcode)
                            OP_VLD: begin
                                state        <= S_LOAD;
                                base_addr    <= addr;
                                idx          <= '0;
                                last_idx     <= LAST_VEC;
                                busy         <= 1'b1;
                                mem.mem_re   <= 1'b1;
                                mem.mem_addr <= addr;
                            end
                            OP_VST, OP_SST: begin
                                state         <= S_STORE;
                                base_addr     <= addr;
                                st_lat        <= st_data;
                                idx           <= '0;
                                last_idx      <= (opcode == OP_VST) ? LAST_VEC : '0;
                                busy          <= 1'b1;
                                mem.mem_we    <= 1'b1;
                                mem.mem_addr  <= addr;
                                mem.mem_wdata <= st_data[LANE_W-1:0];
                            end
                            // NOTE: an unassigned branch in a clocked block
                            // simply holds the flops; no latch can result.
                            default: ;
                        endcase
                    end
                end

                S_LOAD: begin
                    if (mem.mem_ready) begin
                        ld_data[idx*LANE_W +: LANE_W] <= mem.mem_rdata;
                        if (last_lane) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            mem.mem_re   <= 1'b0;
                            mem.mem_addr <= '0;
                        end else begin
                            idx          <= idx_next;
                            mem.mem_addr <= addr_next;
                        end
                    end
                end

                S_STORE: begin
                    if (mem.mem_ready) begin
                        if (last_lane) begin
                            state         <= S_DONE;
                            done          <= 1'b1;
                            mem.mem_we    <= 1'b0;
                            mem.mem_addr  <= '0;
                            mem.mem_wdata <= '0;
                        end else begin
                            idx           <= idx_next;
                            mem.mem_addr  <= addr_next;
                            mem.mem_wdata <= st_lat[idx_next*LANE_W +: LANE_W];
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit: a behavioural word memory, a
// scoreboard of expected bus beats, a table of load/store transactions and
// hand-written reset-abort and ignored-start sequences.
module tb_vector_mem_unit;
    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int ADDR_W = 16;
    localparam int VW     = LANES * LANE_W;

    localparam logic [3:0] OP_VLD  = 4'b0100;
    localparam logic [3:0] OP_VST  = 4'b0101;
    localparam logic [3:0] OP_SST  = 4'b0011;
    localparam logic [3:0] OP_VADD = 4'b0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [VW-1:0]     st_data;
    logic [VW-1:0]     ld_data;
    logic              busy;
    logic              done;

    vector_mem_unit_if #(.ADDR_W(ADDR_W), .LANE_W(LANE_W)) mif ();

    vector_mem_unit #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opcode  (opcode),
        .addr    (addr),
        .st_data (st_data),
        .mem     (mif),
        .ld_data (ld_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write taken on accepted beats.
    logic [LANE_W-1:0] mem_model [65536];
    assign mif.mem_rdata = mif.mem_re ? mem_model[mif.mem_addr] : '0;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] a;
        logic [LANE_W-1:0] d;
    } acc_t;
    acc_t sb[$];

    typedef struct {
        logic [3:0]        op;
        logic [ADDR_W-1:0] a;
        int                mode;      // 0 ready high, 1 alternate, 2 random
        int                lat;       // expected start-to-done cycles, 0 = skip
        int                data_kind; // 0 lane i = i, 1 random, 2 ABCD in lane 0
    } vec_t;

    int            n_pass = 0;
    int            n_total = 0;
    int            ready_mode = 0;
    int            cyc = 0;
    int            accepts = 0;
    int            done_cnt = 0;
    int            viol = 0;
    logic [VW-1:0] exp_ld = '0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // mem_ready pattern, changed just after each rising edge.
    initial begin
        mif.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       mif.mem_ready = 1'b1;
                1:       mif.mem_ready = cyc[0];
                default: mif.mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Bus monitor: scoreboard compare on accepted beats, protocol rules
    // (exclusive strobes, idle zeros, frozen outputs while stalled).
    initial begin
        bit                prev_stall = 1'b0;
        logic [ADDR_W-1:0] p_a = '0;
        logic [LANE_W-1:0] p_d = '0;
        logic              p_re = 1'b0;
        logic              p_we = 1'b0;
        acc_t              e;
        forever begin
            @(negedge clk);
            if (mif.mem_re && mif.mem_we) viol++;
            if (!mif.mem_re && !mif.mem_we && (mif.mem_addr != 0 || mif.mem_wdata != 0)) viol++;
            if (prev_stall && !rst && (mif.mem_re !== p_re || mif.mem_we !== p_we ||
                                       mif.mem_addr !== p_a || mif.mem_wdata !== p_d)) viol++;
            if (done) done_cnt++;
            if ((mif.mem_re || mif.mem_we) && mif.mem_ready) begin
                accepts++;
                if (sb.size() == 0) begin
                    check("sb_extra_access", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_we", mif.mem_we, e.we);
                    check("sb_addr", mif.mem_addr, e.a);
                    if (e.we) check("sb_wdata", mif.mem_wdata, e.d);
                end
                if (mif.mem_we) mem_model[mif.mem_addr] = mif.mem_wdata;
            end
            prev_stall = (mif.mem_re || mif.mem_we) && !mif.mem_ready;
            p_re = mif.mem_re;
            p_we = mif.mem_we;
            p_a  = mif.mem_addr;
            p_d  = mif.mem_wdata;
        end
    end

    // Drive one start pulse and push the beats it should produce.
    task automatic issue(input logic [3:0] op, input logic [ADDR_W-1:0] a, input logic [VW-1:0] d);
        acc_t              e;
        logic [ADDR_W-1:0] la;
        @(negedge clk);
        start   = 1'b1;
        opcode  = op;
        addr    = a;
        st_data = d;
        if (op == OP_VLD) begin
            for (int i = 0; i < LANES; i++) begin
                la = a + ADDR_W'(i);
                e.we = 1'b0; e.a = la; e.d = '0;
                sb.push_back(e);
                exp_ld[i*LANE_W +: LANE_W] = mem_model[la];
            end
        end else if (op == OP_VST) begin
            for (int i = 0; i < LANES; i++) begin
                e.we = 1'b1; e.a = a + ADDR_W'(i); e.d = d[i*LANE_W +: LANE_W];
                sb.push_back(e);
            end
        end else if (op == OP_SST) begin
            e.we = 1'b1; e.a = a; e.d = d[LANE_W-1:0];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        opcode = OP_VADD;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done) begin
                cycles = k;
                break;
            end
        end
        if (cycles == 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input string tag, input vec_t t);
        logic [VW-1:0] d;
        int            c;
        int            d0;
        for (int i = 0; i < LANES; i++) begin
            d[i*LANE_W +: LANE_W] = (t.data_kind == 0) ? LANE_W'(i) : LANE_W'($urandom);
        end
        if (t.data_kind == 2) d[LANE_W-1:0] = 16'hABCD;
        ready_mode = t.mode;
        d0 = done_cnt;
        issue(t.op, t.a, d);
        check({tag, "_busy"}, busy, 1);
        wait_done(c);
        if (t.lat != 0) check({tag, "_latency"}, c, t.lat);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_ld_data"}, ld_data, exp_ld);
    endtask

    vec_t tbl[9];

    initial begin
        int a0;
        int d0;
        int c;

        tbl[0] = '{OP_VLD, 16'h0100, 0, 17, 0};
        tbl[1] = '{OP_VST, 16'h0200, 1,  0, 0};
        tbl[2] = '{OP_VLD, 16'h0200, 0, 17, 0};
        tbl[3] = '{OP_VLD, 16'hFFF8, 2,  0, 0};
        tbl[4] = '{OP_SST, 16'h0010, 0,  2, 2};
        tbl[5] = '{OP_VST, 16'hFFFC, 2,  0, 1};
        tbl[6] = '{OP_VST, 16'h0300, 0, 17, 1};
        tbl[7] = '{OP_SST, 16'hFFFF, 1,  0, 1};
        tbl[8] = '{OP_VLD, 16'h0300, 1,  0, 0};

        for (int i = 0; i < 65536; i++) mem_model[i] = LANE_W'(i) ^ 16'h3D00;

        rst = 1'b1; start = 1'b0; opcode = OP_VADD; addr = '0; st_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_re", mif.mem_re, 0);
        check("rst_we", mif.mem_we, 0);
        check("rst_addr", mif.mem_addr, 0);
        check("rst_wdata", mif.mem_wdata, 0);
        check("rst_ld_data", ld_data, 0);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            run_op($sformatf("vec%0d", k), tbl[k]);
            if (k == 0) begin
                check("vld0100_lane0", ld_data[15:0], 16'h3C00);
                check("vld0100_lane15", ld_data[255:240], 16'h3C0F);
            end
        end

        // Reset in the middle of a VLD, after lanes 0..5 have completed.
        ready_mode = 0;
        a0 = accepts;
        issue(OP_VLD, 16'h0400, '0);
        for (int k = 0; k < 100; k++) begin
            if (accepts - a0 >= 6) break;
            @(posedge clk);
            #2;
        end
        check("abort_reached_lane5", (accepts - a0 >= 6), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_ld = '0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_re", mif.mem_re, 0);
        check("abort_we", mif.mem_we, 0);
        check("abort_addr", mif.mem_addr, 0);
        check("abort_ld_data", ld_data, 0);
        d0 = done_cnt;
        a0 = accepts;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_strobe", accepts - a0, 0);
        run_op("after_abort", '{OP_VLD, 16'h0100, 0, 17, 0});

        // start while busy must not disturb the in-flight transfer.
        ready_mode = 1;
        d0 = done_cnt;
        issue(OP_VLD, 16'h0500, '0);
        repeat (3) @(negedge clk);
        start = 1'b1; opcode = OP_VST; addr = 16'h0900; st_data = {LANES{16'h5A5A}};
        @(posedge clk);
        #1;
        start = 1'b0; opcode = OP_VADD;
        wait_done(c);
        @(negedge clk);
        check("busy_start_done_once", done_cnt - d0, 1);
        check("busy_start_sb_empty", sb.size(), 0);
        check("busy_start_ld_data", ld_data, exp_ld);
        check("busy_start_idle", busy, 0);

        // Non-memory opcode in IDLE is ignored.
        d0 = done_cnt;
        a0 = accepts;
        @(negedge clk);
        start = 1'b1; opcode = OP_VADD; addr = 16'h0A00;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("vadd_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("vadd_no_access", accepts - a0, 0);
        check("vadd_no_done", done_cnt - d0, 0);

        check("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule
